// File: rtl/lzrw1_pkg.sv
// lzrw1_pkg: shared types and constants for the LZRW1 group packer
package lzrw1_pkg;
  localparam logic [4:0] GROUP_SIZE = 5'd16;
  localparam logic [3:0] MIN_MATCH  = 4'd3;
  localparam int OFFSET_W = 12;
  localparam int LEN_W    = 4;
  typedef struct packed {
    logic       is_copy;
    logic [7:0] byte0;
    logic [7:0] byte1;
  } item_t;
  typedef enum logic [1:0] {COLLECT, EMIT_CTRL_LO, EMIT_CTRL_HI, EMIT_ITEMS} pack_state_t;
endpackage

// File: rtl/lzrw1_item_encoder.sv
// lzrw1_item_encoder: maps one incoming item to its byte encoding, demoting illegal copies to literals
module lzrw1_item_encoder
  import lzrw1_pkg::*;
(
  input  logic                ctrl_bit,
  input  logic [7:0]          literal_byte,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [LEN_W-1:0]    length,
  output item_t               item,
  output logic                illegal
);
  logic copy;
  assign illegal = ctrl_bit && (length < MIN_MATCH || offset == '0);
  assign copy    = ctrl_bit && !illegal;
  assign item    = '{is_copy: copy,
                     byte0:   copy ? {offset[11:8], length - 4'd1} : literal_byte,
                     byte1:   offset[7:0]};
endmodule

// File: rtl/lzrw1_group_packer.sv
// lzrw1_group_packer: collects items into 16-item LZRW1 groups and streams them out byte by byte
module lzrw1_group_packer
  import lzrw1_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                InValid,
  output logic                InReady,
  input  logic                ControlBit,
  input  logic [7:0]          LiteralByte,
  input  logic [OFFSET_W-1:0] Offset,
  input  logic [LEN_W-1:0]    Length,
  input  logic                Flush,
  output logic [7:0]          OutData,
  output logic                OutValid,
  input  logic                OutReady,
  output logic                OutLast,
  output logic                FlushDone,
  output logic                ProtocolErr,
  output logic [31:0]         TotalBytes
);
  pack_state_t state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] control_q, control_d;
  item_t       items_q [16];
  item_t       items_d [16];
  logic [3:0]  idx_q, idx_d;
  logic        half_q, half_d, flush_q, flush_d, flush_done_q, flush_done_d, err_q, err_d;
  logic [31:0] total_q, total_d;
  item_t       enc, cur;
  logic        illegal, accept, xfer, last_byte;

  lzrw1_item_encoder u_enc (
    .ctrl_bit     (ControlBit),
    .literal_byte (LiteralByte),
    .offset       (Offset),
    .length       (Length),
    .item         (enc),
    .illegal      (illegal)
  );

  assign cur       = items_q[idx_q];
  assign InReady   = state_q == COLLECT;
  assign OutValid  = !InReady;
  assign accept    = InValid && InReady;
  assign xfer      = OutValid && OutReady;
  // a copy occupies two bytes, so the group ends only on its second half
  assign last_byte = state_q == EMIT_ITEMS && {1'b0, idx_q} == count_q - 5'd1 && (!cur.is_copy || half_q);
  assign OutData   = state_q == EMIT_CTRL_LO ? control_q[7:0] :
                     state_q == EMIT_CTRL_HI ? control_q[15:8] :
                     state_q == EMIT_ITEMS   ? (half_q ? cur.byte1 : cur.byte0) : 8'h00;
  assign OutLast     = last_byte && flush_q;
  assign FlushDone   = flush_done_q;
  assign ProtocolErr = err_q;
  assign TotalBytes  = total_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    control_d    = control_q;
    items_d      = items_q;
    idx_d        = idx_q;
    half_d       = half_q;
    flush_d      = flush_q;
    flush_done_d = 1'b0;
    err_d        = err_q || (accept && illegal);
    total_d      = total_q + {31'd0, xfer};
    case (state_q)
      COLLECT: begin
        if (accept) begin
          items_d[count_q[3:0]]   = enc;
          control_d[count_q[3:0]] = enc.is_copy;
          count_d                 = count_q + 5'd1;
        end
        if ((accept && count_q == GROUP_SIZE - 5'd1) || (Flush && (accept || count_q != '0))) begin
          state_d = EMIT_CTRL_LO;
          flush_d = Flush;
          idx_d   = '0;
          half_d  = 1'b0;
        end else if (Flush) begin
          flush_done_d = 1'b1;
        end
      end
      EMIT_CTRL_LO: state_d = xfer ? EMIT_CTRL_HI : state_q;
      EMIT_CTRL_HI: state_d = xfer ? EMIT_ITEMS : state_q;
      default: begin
        if (xfer) begin
          if (cur.is_copy && !half_q) begin
            half_d = 1'b1;
          end else if (last_byte) begin
            state_d      = COLLECT;
            count_d      = '0;
            control_d    = '0;
            flush_d      = 1'b0;
            flush_done_d = flush_q;
          end else begin
            idx_d  = idx_q + 4'd1;
            half_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      control_q    <= '0;
      items_q      <= '{default: '0};
      idx_q        <= '0;
      half_q       <= 1'b0;
      flush_q      <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
      total_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      control_q    <= control_d;
      items_q      <= items_d;
      idx_q        <= idx_d;
      half_q       <= half_d;
      flush_q      <= flush_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
      total_q      <= total_d;
    end
  end
endmodule

// File: tb/tb_lzrw1_group_packer.sv
// tb_lzrw1_group_packer: randomized self-checking bench against a byte-stream reference model
module tb_lzrw1_group_packer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        InValid = 1'b0, ControlBit = 1'b0, Flush = 1'b0, OutReady;
  logic [7:0]  LiteralByte = 8'h00;
  logic [11:0] Offset = 12'h000;
  logic [3:0]  Length = 4'h0;
  logic        InReady, OutValid, OutLast, FlushDone, ProtocolErr;
  logic [7:0]  OutData;
  logic [31:0] TotalBytes;

  typedef struct {
    bit       c;
    bit [7:0] lit;
    bit [11:0] off;
    bit [3:0] len;
  } titem_t;

  int n_checks = 0, n_fail = 0;
  titem_t items[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       got_last[$];
  int cyc = 0, ready_mode = 0;
  int acc_cyc = -1, first_x = -1, last_x = -1, lastflag_x = -1, fd_cyc = -1, fd_cnt = 0, freq_cyc = -1;
  bit prev_stall = 0;
  logic [7:0] prev_data;
  logic prev_last;
  int total_exp = 0;
  bit err_exp = 0;

  lzrw1_group_packer dut (
    .clock(clock), .reset(reset), .InValid(InValid), .InReady(InReady),
    .ControlBit(ControlBit), .LiteralByte(LiteralByte), .Offset(Offset), .Length(Length),
    .Flush(Flush), .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .OutLast(OutLast), .FlushDone(FlushDone), .ProtocolErr(ProtocolErr), .TotalBytes(TotalBytes)
  );

  always #5 clock = ~clock;

  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      OutReady = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? !OutReady : 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (OutValid !== 1'b1 || OutData !== prev_data || OutLast !== prev_last) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   OutValid, OutData, OutLast, prev_data, prev_last);
        end
      end
      if (OutValid) begin
        n_checks++;
        if (InReady !== 1'b0) begin
          n_fail++;
          $display("FAIL inready_during_emit: got %b, required 0", InReady);
        end
      end
      if (InValid && InReady) acc_cyc = cyc;
      if (Flush && InReady && !InValid) freq_cyc = cyc;
      if (FlushDone) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (OutValid && OutReady) begin
        got_q.push_back(OutData);
        got_last.push_back(OutLast);
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        if (OutLast) lastflag_x = cyc;
      end
      prev_stall = OutValid && !OutReady;
      prev_data  = OutData;
      prev_last  = OutLast;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit legal(titem_t it);
    return it.c && it.len >= 4'd3 && it.off != 12'd0;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    got_last.delete();
    first_x = -1; last_x = -1; lastflag_x = -1; fd_cnt = 0; fd_cyc = -1;
  endtask

  task automatic build_exp();
    bit [15:0] ctrl = '0;
    exp_q.delete();
    foreach (items[i]) if (legal(items[i])) ctrl[i] = 1'b1;
    exp_q.push_back(ctrl[7:0]);
    exp_q.push_back(ctrl[15:8]);
    foreach (items[i]) begin
      if (legal(items[i])) begin
        exp_q.push_back({items[i].off[11:8], items[i].len - 4'd1});
        exp_q.push_back(items[i].off[7:0]);
      end else begin
        exp_q.push_back(items[i].lit);
      end
      if (items[i].c && !legal(items[i])) err_exp = 1;
    end
  endtask

  task automatic send(input titem_t it, input bit fl);
    int b = 0;
    while (!InReady && b < 2000) begin
      tick();
      b++;
    end
    if (!InReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL inready_timeout: got InReady=0 after %0d cycles, required 1", b);
    end
    InValid = 1; ControlBit = it.c; LiteralByte = it.lit; Offset = it.off; Length = it.len; Flush = fl;
    tick();
    InValid = 0; Flush = 0;
  endtask

  task automatic add(input bit c, input bit [7:0] lit, input bit [11:0] off, input bit [3:0] len);
    titem_t t;
    t.c = c; t.lit = lit; t.off = off; t.len = len;
    items.push_back(t);
  endtask

  // fl: 0 no flush, 1 flush in a separate cycle, 2 flush alongside the last item
  task automatic run_group(input string name, input int fl, input int mode);
    int b = 0;
    logic [7:0] g;
    logic gl;
    ready_mode = mode;
    build_exp();
    clear_mon();
    foreach (items[i]) send(items[i], fl == 2 && i == items.size() - 1);
    if (fl == 1) begin
      Flush = 1;
      tick();
      Flush = 0;
    end
    while (got_q.size() < exp_q.size() && b < 3000) begin
      tick();
      b++;
    end
    repeat (3) tick();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s byte_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g  = i < got_q.size() ? got_q[i] : 8'hxx;
      gl = i < got_q.size() ? got_last[i] : 1'bx;
      n_checks++;
      if (g !== exp_q[i] || gl !== (fl != 0 && i == exp_q.size() - 1)) begin
        n_fail++;
        $display("FAIL %s byte[%0d]: got %h last=%b, required %h last=%b", name, i, g, gl,
                 exp_q[i], fl != 0 && i == exp_q.size() - 1);
      end
    end
    total_exp += exp_q.size();
    n_checks++;
    if (TotalBytes !== 32'(total_exp)) begin
      n_fail++;
      $display("FAIL %s total_bytes: got %0d, required %0d", name, TotalBytes, total_exp);
    end
    n_checks++;
    if (fl != 0 ? (fd_cnt != 1 || fd_cyc != lastflag_x + 1) : fd_cnt != 0) begin
      n_fail++;
      $display("FAIL %s flush_done: got %0d pulses at cycle %0d, required %0d after last byte at %0d",
               name, fd_cnt, fd_cyc, fl != 0 ? 1 : 0, lastflag_x);
    end
    n_checks++;
    if (ProtocolErr !== err_exp || InReady !== 1'b1) begin
      n_fail++;
      $display("FAIL %s status: got err=%b inready=%b, required err=%b inready=1", name, ProtocolErr, InReady, err_exp);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (OutValid !== 0 || InReady !== 1 || OutData !== 0 || OutLast !== 0 || FlushDone !== 0 ||
        ProtocolErr !== 0 || TotalBytes !== 0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b r=%b d=%h l=%b fd=%b e=%b t=%0d, required v=0 r=1 d=00 l=0 fd=0 e=0 t=0",
               OutValid, InReady, OutData, OutLast, FlushDone, ProtocolErr, TotalBytes);
    end
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_literals();
    items.delete();
    for (int i = 0; i < 16; i++) add(0, 8'(8'h41 + i), 12'h0, 4'h0);
    run_group("literals16", 0, 0);
    n_checks++;
    if (first_x != acc_cyc + 1 || last_x - first_x != 17) begin
      n_fail++;
      $display("FAIL latency: got first=%0d last=%0d, required first=%0d last=%0d",
               first_x, last_x, acc_cyc + 1, acc_cyc + 18);
    end
  endtask

  task automatic test_copy_flush();
    items.delete();
    add(1, 8'h00, 12'hABC, 4'd4);
    run_group("copy_flush", 1, 0);
  endtask

  task automatic test_stall();
    items.delete();
    add(1, 8'h00, 12'h123, 4'd5);
    for (int i = 0; i < 15; i++) add(0, 8'(i), 12'h0, 4'h0);
    run_group("stall_toggle", 0, 1);
  endtask

  task automatic test_illegal();
    items.delete();
    add(1, 8'h7F, 12'h010, 4'd2);
    run_group("illegal_copy", 1, 0);
    items.delete();
    add(0, 8'h11, 12'h0, 4'h0);
    add(1, 8'h22, 12'h000, 4'd9);
    run_group("illegal_sticky", 1, 0);
  endtask

  task automatic test_empty_flush();
    clear_mon();
    ready_mode = 0;
    Flush = 1;
    tick();
    Flush = 0;
    repeat (3) tick();
    n_checks++;
    if (got_q.size() != 0 || fd_cnt != 1 || fd_cyc != freq_cyc + 1) begin
      n_fail++;
      $display("FAIL empty_flush: got %0d bytes, %0d pulses at %0d, required 0 bytes, 1 pulse at %0d",
               got_q.size(), fd_cnt, fd_cyc, freq_cyc + 1);
    end
  endtask

  task automatic test_random();
    for (int g = 0; g < 8; g++) begin
      int n = $urandom_range(1, 16);
      int fl = n < 16 ? 1 + int'($urandom_range(0, 1)) : 2 * int'($urandom_range(0, 1));
      items.delete();
      for (int i = 0; i < n; i++)
        add(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 5) == 0 ? 12'h0 : 12'($urandom),
            4'($urandom_range(0, 15)));
      run_group("random", fl, 2);
    end
  endtask

  task automatic test_reset_mid_emit();
    int b = 0;
    items.delete();
    for (int i = 0; i < 16; i++) add(0, 8'(i * 3), 12'h0, 4'h0);
    ready_mode = 1;
    clear_mon();
    foreach (items[i]) send(items[i], 0);
    while (got_q.size() < 4 && b < 200) begin
      tick();
      b++;
    end
    reset = 1;
    #1;
    n_checks++;
    if (b >= 200 || OutValid !== 0 || InReady !== 1 || TotalBytes !== 0 || ProtocolErr !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_emit: got v=%b r=%b t=%0d e=%b wait=%0d, required v=0 r=1 t=0 e=0",
               OutValid, InReady, TotalBytes, ProtocolErr, b);
    end
    tick();
    reset = 0;
    total_exp = 0;
    err_exp = 0;
    tick();
    items.delete();
    for (int i = 0; i < 16; i++) add(0, 8'(8'h41 + i), 12'h0, 4'h0);
    run_group("after_reset", 0, 0);
  endtask

  initial begin
    test_reset();
    test_literals();
    test_copy_flush();
    test_stall();
    test_illegal();
    test_empty_flush();
    test_random();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lzrw1_group_packer.md
Name: lzrw1_group_packer

Overview:
- Downstream neighbour of the pointer-table stage. Consumes one item per handshake: a literal byte, or a copy with a 12-bit offset and 4-bit length, qualified by ControlBit.
- Collects items into LZRW1 groups of 16, each preceded by a 16-bit control word.
- Emits the compressed stream one byte per cycle over a valid/ready interface toward the output buffer.
- Flush closes a partial group at end of block.

Parameters:
- GROUP_SIZE, 16, items per control group (fixed by format; not overridable)
- MIN_MATCH, 3, minimum legal copy length

Ports:
- clock, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- InValid, input, 1, item present
- InReady, output, 1, packer can accept an item this cycle
- ControlBit, input, 1, 1 = copy item, 0 = literal
- LiteralByte, input, 8, literal value (used when ControlBit = 0)
- Offset, input, 12, copy distance (used when ControlBit = 1)
- Length, input, 4, copy length (used when ControlBit = 1)
- Flush, input, 1, end of block: close the current group
- OutData, output, 8, compressed byte
- OutValid, output, 1, OutData valid
- OutReady, input, 1, consumer accepts OutData
- OutLast, output, 1, final byte of a flushed block
- FlushDone, output, 1, one-cycle pulse when a flush has completed
- ProtocolErr, output, 1, sticky flag: an illegal copy was demoted to a literal
- TotalBytes, output, 32, count of bytes accepted by the consumer since reset (wraps)

Behaviour:
- Reset values (asynchronous):
  - all outputs 0 except InReady = 1
  - state COLLECT, item count 0, control word 0, TotalBytes 0
- A reset mid-emit discards the group; no recovery.
- Handshakes:
  - Item accepted when InValid && InReady.
  - Byte transfers when OutValid && OutReady.
  - OutData and OutLast are held stable while OutValid && !OutReady.
- Item encoding:
  - Literal: one byte, LiteralByte.
  - Copy: two bytes. byte0 = {Offset[11:8], Length-1}, byte1 = Offset[7:0].
  - Control bit i = 1 when item i is a copy; item 0 maps to bit 0.
- Illegal copy:
  - Condition: ControlBit = 1 with Length < MIN_MATCH or Offset = 0.
  - Stored as a literal (LiteralByte, control bit 0); ProtocolErr set until reset.
- States:
  - COLLECT: InReady = 1. Each accepted item is stored and count increments.
    - Count reaches 16 → EMIT_CTRL_LO on the next cycle.
    - Flush with count > 0 (including an item accepted in the same cycle) → EMIT_CTRL_LO with the flush marker set.
    - Flush with count 0 and no item accepted → FlushDone pulses the next cycle; no bytes emitted.
  - EMIT_CTRL_LO: OutData = control[7:0]; on transfer → EMIT_CTRL_HI.
  - EMIT_CTRL_HI: OutData = control[15:8]; on transfer → EMIT_ITEMS.
  - EMIT_ITEMS: walks items 0..count-1, one byte per transfer (copies take two).
    - After the last byte transfers: clear count and control → COLLECT.
    - If the flush marker is set: OutLast = 1 on that byte, and FlushDone pulses the cycle after its transfer.
- Unused control bits in a partial group are 0.
- InReady = 0 in every EMIT state; Flush is ignored outside COLLECT.
- Latency: the 16th item accepted in cycle N gives OutValid in cycle N+1. With OutReady held high, a full group completes in 2 + sum(item bytes) cycles.
- TotalBytes increments on every output transfer.

Decomposition:
- Package lzrw1_pkg holds:
  - item_t struct {is_copy, byte0, byte1}
  - GROUP_SIZE, MIN_MATCH, OFFSET_W = 12, LEN_W = 4
  - state enum pack_state_t
- One sub-module, lzrw1_item_encoder (combinational): maps ControlBit/LiteralByte/Offset/Length to item_t plus the illegal-copy flag.

Test Plan:
- 16 literals 0x41..0x50, OutReady = 1 → bytes 00 00 41..50 (18 bytes); OutLast never set; TotalBytes = 18.
- Copy Offset = 0xABC, Length = 4, then Flush → bytes 01 00 A3 BC; OutLast on BC; FlushDone pulses one cycle later.
- Item 0 a copy (Offset 0x123, Length 5) plus 15 literals 0x00..0x0E, OutReady toggled every other cycle → 01 00 14 23 00..0E; output held stable while stalled; InReady stays 0 until the last byte transfers.
- ControlBit = 1, Length = 2, LiteralByte = 0x7F, then Flush → 00 00 7F; ProtocolErr = 1 and remains set.
- Flush with an empty buffer → no OutValid; FlushDone pulses the next cycle.
- Assert reset during EMIT_ITEMS → OutValid drops immediately; InReady = 1; TotalBytes = 0; a following 16-literal group emits correctly.
